// File: rtl/fifo_dot_mac.sv
// Dot-product consumer for two operand FIFOs: pops LENGTH pairs, multiplies and accumulates them.
// Optional macro MAC_SATURATE_EN clamps the accumulator instead of wrapping and reports it on sat.
module fifo_dot_mac #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LENGTH     = 8,
  parameter int unsigned ACC_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  a_empty,
  input  logic                  b_empty,
  input  logic [DATA_WIDTH-1:0] a_data,
  input  logic [DATA_WIDTH-1:0] b_data,
  output logic                  a_rden,
  output logic                  b_rden,
  output logic                  busy,
  output logic                  done,
  output logic [ACC_WIDTH-1:0]  result,
  output logic                  sat
);

  localparam int unsigned CW = $clog2(LENGTH + 1);
  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned SW = ACC_WIDTH + 1;
  localparam logic [CW-1:0] LEN_C  = CW'(LENGTH);
  localparam logic [CW-1:0] LAST_C = CW'(LENGTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            drain_q, drain_d;
  logic            vld_q, prod_vld_q;
  logic [PW-1:0]   prod_q;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [SW-1:0]   sum;
  logic            pop;
`ifdef MAC_SATURATE_EN
  logic            sat_q, sat_d;
`endif

  // Both FIFOs are always popped as a pair; reset gates the pop combinationally.
  assign pop = rst_n && (state_q == S_RUN) && !a_empty && !b_empty && (cnt_q < LEN_C);
  assign sum = {1'b0, acc_q} + SW'(prod_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    acc_d   = acc_q;
`ifdef MAC_SATURATE_EN
    sat_d   = sat_q;
`endif
    if (prod_vld_q) begin
`ifdef MAC_SATURATE_EN
      if (sum[ACC_WIDTH]) begin
        acc_d = '1;
        sat_d = 1'b1;
      end else begin
        acc_d = sum[ACC_WIDTH-1:0];
      end
`else
      acc_d = sum[ACC_WIDTH-1:0];
`endif
    end
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          cnt_d   = '0;
          acc_d   = '0;
`ifdef MAC_SATURATE_EN
          sat_d   = 1'b0;
`endif
        end
      end
      S_RUN: begin
        if (pop) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_C) begin
            state_d = S_DRAIN;
            drain_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        drain_d = 1'b1;
        if (drain_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      drain_q    <= 1'b0;
      vld_q      <= 1'b0;
      prod_vld_q <= 1'b0;
      prod_q     <= '0;
      acc_q      <= '0;
`ifdef MAC_SATURATE_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      vld_q      <= pop;
      prod_vld_q <= vld_q;
      if (vld_q) begin
        prod_q <= {{DATA_WIDTH{1'b0}}, a_data} * {{DATA_WIDTH{1'b0}}, b_data};
      end
      acc_q      <= acc_d;
`ifdef MAC_SATURATE_EN
      sat_q      <= sat_d;
`endif
    end
  end

  assign a_rden = pop;
  assign b_rden = pop;
  assign busy   = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done   = (state_q == S_DONE);
  assign result = acc_q;
`ifdef MAC_SATURATE_EN
  assign sat    = sat_q;
`else
  assign sat    = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_dot_mac.sv
// Directed bench for fifo_dot_mac: three parameterisations share one behavioural FIFO pair.
// Honours MAC_SATURATE_EN for the 16-bit accumulator case.
module tb_fifo_dot_mac;

  logic clk = 1'b0;
  logic rst_n, start, b_block;
  logic a_empty, b_empty;
  logic [7:0] a_data = '0, b_data = '0;
  int sel;
  int checks = 0, failures = 0;

  logic a8_rden, b8_rden, busy8, done8, sat8;
  logic [23:0] res8;
  logic a1_rden, b1_rden, busy1, done1, sat1;
  logic [23:0] res1;
  logic a16_rden, b16_rden, busy16, done16, sat16;
  logic [15:0] res16;

  logic a_rden_m, b_rden_m, busy_m, done_m, sat_m;
  logic [23:0] res_m;

  logic [7:0] ma [128];
  logic [7:0] mb [128];
  int a_wr = 0, b_wr = 0, a_rd = 0, b_rd = 0;

  always #5 clk = ~clk;

  fifo_dot_mac u8 (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 0), .a_empty(a_empty), .b_empty(b_empty),
    .a_data(a_data), .b_data(b_data), .a_rden(a8_rden), .b_rden(b8_rden), .busy(busy8),
    .done(done8), .result(res8), .sat(sat8));

  fifo_dot_mac #(.DATA_WIDTH(8), .LENGTH(1), .ACC_WIDTH(24)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 1), .a_empty(a_empty), .b_empty(b_empty),
    .a_data(a_data), .b_data(b_data), .a_rden(a1_rden), .b_rden(b1_rden), .busy(busy1),
    .done(done1), .result(res1), .sat(sat1));

  fifo_dot_mac #(.DATA_WIDTH(8), .LENGTH(2), .ACC_WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start && sel == 2), .a_empty(a_empty), .b_empty(b_empty),
    .a_data(a_data), .b_data(b_data), .a_rden(a16_rden), .b_rden(b16_rden), .busy(busy16),
    .done(done16), .result(res16), .sat(sat16));

  always_comb begin
    a_rden_m = a8_rden; b_rden_m = b8_rden; busy_m = busy8; done_m = done8;
    res_m = res8; sat_m = sat8;
    if (sel == 1) begin
      a_rden_m = a1_rden; b_rden_m = b1_rden; busy_m = busy1; done_m = done1;
      res_m = res1; sat_m = sat1;
    end else if (sel == 2) begin
      a_rden_m = a16_rden; b_rden_m = b16_rden; busy_m = busy16; done_m = done16;
      res_m = {8'd0, res16}; sat_m = sat16;
    end
  end

  // Behavioural FIFOs: output register loads the cycle after a read enable.
  assign a_empty = (a_rd == a_wr);
  assign b_empty = (b_rd == b_wr) || b_block;
  always @(posedge clk) begin
    if (a_rden_m) begin a_data <= ma[a_rd]; a_rd <= a_rd + 1; end
    if (b_rden_m) begin b_data <= mb[b_rd]; b_rd <= b_rd + 1; end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    ma[a_wr] = a; a_wr++;
    mb[b_wr] = b; b_wr++;
  endtask

  task automatic flush();
    a_wr = a_rd;
    b_wr = b_rd;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start sampled in cycle 0; observes cycles 1..ncyc at the falling edge.
  task automatic run_op(input int sel_i, input int ncyc, input int stall_lo, input int stall_hi,
                        input int start_last, output int pops, output int done_cyc,
                        output int done_n, output int mism, output logic [23:0] res_done,
                        output logic last_busy);
    sel = sel_i;
    pops = 0; done_cyc = -1; done_n = 0; mism = 0; res_done = '0; last_busy = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      start   = (c <= start_last);
      b_block = (c >= stall_lo) && (c <= stall_hi);
      #1;
      if (a_rden_m) pops++;
      if (a_rden_m !== b_rden_m) mism++;
      if (done_m) begin
        done_n++;
        if (done_cyc < 0) begin done_cyc = c; res_done = res_m; end
      end
      last_busy = busy_m;
    end
    start = 1'b0;
    b_block = 1'b0;
  endtask

  initial begin
    int pops, dc, dn, mm;
    logic [23:0] rd;
    logic lb;
    rst_n = 1'b0; start = 1'b0; b_block = 1'b0; sel = 0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_rden", {63'd0, a8_rden}, 64'd0);
    check("rst_busy", {63'd0, busy8}, 64'd0);
    check("rst_done", {63'd0, done8}, 64'd0);
    check("rst_result", {40'd0, res8}, 64'd0);
    check("rst_sat", {61'd0, sat8, sat1, sat16}, 64'd0);
    rst_n = 1'b1;

    // Basic operation: 1..8 times 2
    for (int i = 1; i <= 8; i++) push(8'(i), 8'd2);
    run_op(0, 20, -1, -1, 0, pops, dc, dn, mm, rd, lb);
    check("basic_pops", 64'(pops), 64'd8);
    check("basic_done_cyc", 64'(dc), 64'd11);
    check("basic_result", {40'd0, rd}, 64'd72);
    check("basic_hold", {40'd0, res_m}, 64'd72);
    check("basic_sat", {63'd0, sat_m}, 64'd0);
    check("basic_pair", 64'(mm), 64'd0);

    // B empty in cycles 3..5
    for (int i = 1; i <= 8; i++) push(8'(i), 8'd2);
    run_op(0, 22, 3, 5, 0, pops, dc, dn, mm, rd, lb);
    check("stall_pops", 64'(pops), 64'd8);
    check("stall_done_cyc", 64'(dc), 64'd14);
    check("stall_result", {40'd0, rd}, 64'd72);
    check("stall_pair", 64'(mm), 64'd0);

    // start held through RUN..DONE, then a second operation with B=3
    for (int i = 1; i <= 8; i++) push(8'(i), 8'd2);
    run_op(0, 20, -1, -1, 11, pops, dc, dn, mm, rd, lb);
    check("held_done_count", 64'(dn), 64'd1);
    check("held_result", {40'd0, rd}, 64'd72);
    check("held_idle_after", {63'd0, lb}, 64'd0);
    for (int i = 1; i <= 8; i++) push(8'(i), 8'd3);
    run_op(0, 20, -1, -1, 0, pops, dc, dn, mm, rd, lb);
    check("second_result", {40'd0, rd}, 64'd108);
    check("second_done_cyc", 64'(dc), 64'd11);

    // Reset for one cycle after the 4th pop
    for (int i = 1; i <= 8; i++) push(8'(i), 8'd2);
    sel = 0;
    pops = 0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (a_rden_m) pops++;
    end
    check("rst_pre_pops", 64'(pops), 64'd4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_a_rden", {63'd0, a8_rden}, 64'd0);
    check("rst_mid_b_rden", {63'd0, b8_rden}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_after_busy", {63'd0, busy8}, 64'd0);
    check("rst_after_done", {63'd0, done8}, 64'd0);
    check("rst_after_result", {40'd0, res8}, 64'd0);
    check("rst_after_rden", {62'd0, a8_rden, b8_rden}, 64'd0);
    flush();
    for (int i = 1; i <= 8; i++) push(8'(i), 8'(i));
    run_op(0, 20, -1, -1, 0, pops, dc, dn, mm, rd, lb);
    check("rst_fresh_result", {40'd0, rd}, 64'd204);
    check("rst_fresh_pops", 64'(pops), 64'd8);

    // LENGTH=1
    push(8'd3, 8'd5);
    run_op(1, 8, -1, -1, 0, pops, dc, dn, mm, rd, lb);
    check("len1_pops", 64'(pops), 64'd1);
    check("len1_done_cyc", 64'(dc), 64'd4);
    check("len1_result", {40'd0, rd}, 64'd15);

    // 16-bit accumulator overflow
    push(8'd255, 8'd255);
    push(8'd255, 8'd255);
    run_op(2, 8, -1, -1, 0, pops, dc, dn, mm, rd, lb);
    check("acc16_done_cyc", 64'(dc), 64'd5);
`ifdef MAC_SATURATE_EN
    check("acc16_result", {40'd0, rd}, 64'd65535);
    check("acc16_sat", {63'd0, sat_m}, 64'd1);
`else
    check("acc16_result", {40'd0, rd}, 64'd64514);
    check("acc16_sat", {63'd0, sat_m}, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_dot_mac.md
# fifo_dot_mac

Downstream consumer for a pair of operand FIFOs. On `start`, it pops exactly LENGTH element pairs from FIFO A and FIFO B, multiplies each pair, and accumulates the products into a dot-product result. It drives the FIFOs' read enables directly and tolerates empty stalls. The result is held for the control logic or host until the next `start`.

## Interface
- DATA_WIDTH, 8: width of each FIFO element; unsigned.
- LENGTH, 8: element pairs consumed per operation; must be at least 1.
- ACC_WIDTH, 24: accumulator and result width; must be at least 2*DATA_WIDTH.

- clk  in  1  single clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- a_empty  in  1  empty flag of FIFO A.
- b_empty  in  1  empty flag of FIFO B.
- a_data  in  DATA_WIDTH  FIFO A output; valid the cycle after `a_rden`.
- b_data  in  DATA_WIDTH  FIFO B output; valid the cycle after `b_rden`.
- a_rden  out  1  pop FIFO A.
- b_rden  out  1  pop FIFO B; always equal to `a_rden`.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse; `result` is final.
- result  out  ACC_WIDTH  accumulator value.
- sat  out  1  saturation occurred this operation (see Configuration).

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN when `start`=1. Acceptance clears the accumulator, the pop counter and `sat`.
- `start` is ignored in RUN, DRAIN and DONE.
- RUN:
  - `a_rden`=`b_rden`=1 when `rst_n`=1 AND state=RUN AND `a_empty`=0 AND `b_empty`=0 AND pops<LENGTH. This is combinational.
  - Each pop increments the pop counter.
  - Both FIFOs are always popped together; never one without the other.
- RUN -> DRAIN in the cycle the LENGTH-th pop is issued.
- DRAIN lasts exactly 2 cycles to flush the pipeline, then -> DONE.
- DONE lasts one cycle with `done`=1, then -> IDLE.
- Pipeline:
  - Stage 1: a pop registers a valid bit.
  - Stage 2: on that valid bit, the product register loads `a_data*b_data`, full 2*DATA_WIDTH unsigned.
  - Stage 3: the accumulator adds the zero-extended product.
- Without saturation, the accumulator wraps modulo 2^ACC_WIDTH.
- `result` is the accumulator register. It is stable from DONE until the next accepted `start`.
- Empty stalls: while either FIFO is empty, no pop is issued and the counter holds. The operation resumes with no lost or duplicated element.
- Reset, including mid-operation:
  - Next state is IDLE; the accumulator, product, valid bit, counter, `result`, `done`, `busy` and `sat` all go to 0.
  - `a_rden`/`b_rden` are 0 in every cycle where `rst_n`=0.
  - FIFO contents are not touched; the FIFOs' own reset handles them.

## Timing
- Reset values: every output is 0.
- Read latency: pop at cycle t, data sampled at the end of t+1, product registered at the end of t+1, accumulator updated at the end of t+2.
- With no stalls and `start` sampled at cycle 0:
  - pops occur in cycles 1..LENGTH;
  - DRAIN occupies cycles LENGTH+1 and LENGTH+2;
  - `done`=1 in cycle LENGTH+3.
- Each empty-stall cycle adds exactly one cycle to the `done` latency.
- `busy` is 1 in cycles 1..LENGTH+2 and 0 in the DONE cycle.

## Configuration
- Macro MAC_SATURATE_EN.
- Defined:
  - the accumulator clamps at 2^ACC_WIDTH-1 instead of wrapping;
  - `sat` goes high on the first clamping add and stays high until the next accepted `start` or reset.
- Undefined: the accumulator wraps and `sat` is tied to 0.

## Test plan
- LENGTH=8, A preloaded with 1..8, B with eight 2s, `start` pulsed: 8 consecutive pops, `done` in cycle 11, `result`=72, `sat`=0.
- Same data, but B is empty for cycles 3-5 after `start`: no pops during the empty window, exactly 8 pops total, `done` 3 cycles later (cycle 14), `result`=72.
- `start` held high through RUN and DONE: only one operation runs, with `done` pulsing once. A second `start` after IDLE clears the accumulator, and the next `result` again equals the new dot product.
- `rst_n`=0 for one cycle after the 4th pop:
  - `a_rden` is 0 that cycle;
  - all outputs are 0 the next cycle;
  - the state is IDLE;
  - a new `start` with fresh data yields the correct result.
- ACC_WIDTH=16, DATA_WIDTH=8, all operands 255, LENGTH=2: the sum 130050 wraps to 64514 with `sat`=0. With MAC_SATURATE_EN defined, `result`=65535 and `sat`=1.
- LENGTH=1, A=3, B=5: one pop, `done` in cycle 4, `result`=15.
